// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_pkg : shared types and constants for the hazard controller    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hazard_pkg;
   typedef enum logic {FETCH = 1'b0, KILL = 1'b1} fetch_st_e;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : saturating up-counter with synchronous clear           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_q
);
   logic [CNT_W-1:0] r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else if (i_clr) begin
         r_q <= '0;
      end else if (i_inc && (r_q != {CNT_W{1'b1}})) begin
         r_q <= r_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_q = r_q;
endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_ctrl : stall/flush control for the 5-stage pipeline           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [4:0]       i_rs1_D,
   input  logic [4:0]       i_rs2_D,
   input  logic [4:0]       i_rd_E,
   input  logic             i_memread_E,
   input  logic             i_pcsrc_E,
   input  logic             i_imem_ready,
   input  logic             i_dmem_req_M,
   input  logic             i_dmem_ready_M,
   input  logic             i_cnt_clr,
   output logic             o_stall_F,
   output logic             o_stall_D,
   output logic             o_flush_D,
   output logic             o_stall_E,
   output logic             o_flush_E,
   output logic             o_stall_M,
   output logic             o_flush_W,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_kill_cnt
);
   fetch_st_e r_state;
   fetch_st_e w_state_nxt;
   logic      w_freeze;
   logic      w_lwstall;
   logic      w_redir;
   logic      w_flush_D_raw;
   logic      w_kill_done;

   assign w_freeze  = i_dmem_req_M & ~i_dmem_ready_M;
   assign w_lwstall = i_memread_E & (i_rd_E != REG_ZERO) &
                      ((i_rd_E == i_rs1_D) | (i_rd_E == i_rs2_D));
   assign w_redir   = i_pcsrc_E & ~w_freeze;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_kill_done   = 1'b0;
      o_stall_F     = 1'b0;
      o_stall_D     = 1'b0;
      w_flush_D_raw = 1'b0;
      o_stall_E     = 1'b0;
      o_flush_E     = 1'b0;
      o_stall_M     = 1'b0;
      o_flush_W     = 1'b0;

      // The stale-fetch FSM advances independently of the stall priority.
      case (r_state)
         FETCH: if (w_redir && !i_imem_ready) w_state_nxt = KILL;
         KILL: begin
            if (i_imem_ready) begin
               w_state_nxt = FETCH;
               w_kill_done = 1'b1;
            end
         end
         default: w_state_nxt = FETCH;
      endcase

      if (w_freeze) begin
         o_stall_F = 1'b1;
         o_stall_D = 1'b1;
         o_stall_E = 1'b1;
         o_stall_M = 1'b1;
         o_flush_W = 1'b1;
      end else if (w_redir) begin
         w_flush_D_raw = 1'b1;
         o_flush_E     = 1'b1;
      end else begin
         if (w_lwstall) begin
            o_stall_F = 1'b1;
            o_stall_D = 1'b1;
            o_flush_E = 1'b1;
         end
         if ((r_state == KILL) || !i_imem_ready) begin
            o_stall_F     = 1'b1;
            w_flush_D_raw = 1'b1;
         end
      end
   end

   // A held IF/ID register cannot also be bubbled.
   assign o_flush_D = w_flush_D_raw & ~o_stall_D;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (i_cnt_clr),
      .i_inc   (o_stall_F),
      .o_q     (o_stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_kill_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (i_cnt_clr),
      .i_inc   (w_kill_done),
      .o_q     (o_kill_cnt)
   );
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_ctrl : self-checking bench for hazard_ctrl                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hazard_ctrl;
   localparam int CNT_W = 16;
   localparam int CAP   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [4:0]       rs1_D = '0, rs2_D = '0, rd_E = '0;
   logic             memread_E = 1'b0, pcsrc_E = 1'b0, imem_ready = 1'b1;
   logic             dmem_req_M = 1'b0, dmem_ready_M = 1'b0, cnt_clr = 1'b0;
   logic             stall_F, stall_D, flush_D, stall_E, flush_E, stall_M, flush_W;
   logic [CNT_W-1:0] stall_cnt, kill_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   bit m_kill = 1'b0;
   int m_stall_cnt = 0;
   int m_kill_cnt  = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_rs1_D        (rs1_D),
      .i_rs2_D        (rs2_D),
      .i_rd_E         (rd_E),
      .i_memread_E    (memread_E),
      .i_pcsrc_E      (pcsrc_E),
      .i_imem_ready   (imem_ready),
      .i_dmem_req_M   (dmem_req_M),
      .i_dmem_ready_M (dmem_ready_M),
      .i_cnt_clr      (cnt_clr),
      .o_stall_F      (stall_F),
      .o_stall_D      (stall_D),
      .o_flush_D      (flush_D),
      .o_stall_E      (stall_E),
      .o_flush_E      (flush_E),
      .o_stall_M      (stall_M),
      .o_flush_W      (flush_W),
      .o_stall_cnt    (stall_cnt),
      .o_kill_cnt     (kill_cnt)
   );

   // {stall_F, stall_D, flush_D, stall_E, flush_E, stall_M, flush_W}
   wire [6:0] w_dut = {stall_F, stall_D, flush_D, stall_E, flush_E, stall_M, flush_W};

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   function automatic bit m_freeze();
      return dmem_req_M && !dmem_ready_M;
   endfunction

   function automatic bit m_redir();
      return pcsrc_E && !m_freeze();
   endfunction

   function automatic logic [6:0] m_outs();
      bit lw;
      lw = memread_E && (rd_E != 0) && (rd_E == rs1_D || rd_E == rs2_D);
      if (m_freeze())               return 7'b1101011;
      if (m_redir())                return 7'b0010100;
      if (lw)                       return 7'b1100100;
      if (m_kill || !imem_ready)    return 7'b1010000;
      return 7'b0000000;
   endfunction

   task automatic model_reset();
      m_kill = 1'b0;
      m_stall_cnt = 0;
      m_kill_cnt = 0;
   endtask

   // Per-cycle compare against the model, then advance the model on the edge.
   initial begin
      logic [6:0] o;
      bit nk;
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         chk("outputs", {25'd0, w_dut}, {25'd0, m_outs()});
         chk("stall_cnt", {16'd0, stall_cnt}, m_stall_cnt);
         chk("kill_cnt", {16'd0, kill_cnt}, m_kill_cnt);
         @(posedge clk);
         if (!rst_n) begin
            model_reset();
         end else begin
            o  = m_outs();
            nk = m_kill ? !imem_ready : (m_redir() && !imem_ready);
            if (cnt_clr) begin
               m_stall_cnt = 0;
               m_kill_cnt  = 0;
            end else begin
               if (o[6] && m_stall_cnt < CAP) m_stall_cnt++;
               if (m_kill && imem_ready && m_kill_cnt < CAP) m_kill_cnt++;
            end
            m_kill = nk;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      memread_E = 0; pcsrc_E = 0; imem_ready = 1; dmem_req_M = 0;
      dmem_ready_M = 0; cnt_clr = 0; rs1_D = 0; rs2_D = 0; rd_E = 0;
   endtask

   initial begin
      idle();
      @(negedge clk);
      chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("rst_outs", {25'd0, w_dut}, 32'd0);
      step(); rst_n = 1;
      step();

      // load-use hazard
      memread_E = 1; rd_E = 5; rs1_D = 5; rs2_D = 7;
      @(negedge clk); chk("lwstall", {25'd0, w_dut}, {25'd0, 7'b1100100});
      step(); memread_E = 0;
      @(negedge clk); chk("lw_after", {25'd0, w_dut}, 32'd0);
      step(); memread_E = 1; rd_E = 0; rs1_D = 0;
      @(negedge clk); chk("lw_x0", {25'd0, w_dut}, 32'd0);
      step(); idle();

      // redirect with fetch complete
      pcsrc_E = 1;
      @(negedge clk); chk("redir", {25'd0, w_dut}, {25'd0, 7'b0010100});
      step(); pcsrc_E = 0;
      @(negedge clk); chk("redir_fetch", {25'd0, w_dut}, 32'd0);

      // redirect with fetch outstanding -> KILL for 3 cycles
      step(); pcsrc_E = 1; imem_ready = 0;
      step(); pcsrc_E = 0;
      for (int i = 0; i < 3; i++) begin
         imem_ready = (i == 2);
         @(negedge clk); chk("kill_cyc", {25'd0, w_dut}, {25'd0, 7'b1010000});
         step();
      end
      imem_ready = 1;
      @(negedge clk);
      chk("kill_exit", {25'd0, w_dut}, 32'd0);
      chk("kill_cnt1", {16'd0, kill_cnt}, 32'd1);

      // data-memory freeze hides a pending redirect
      step(); dmem_req_M = 1; dmem_ready_M = 0; pcsrc_E = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("freeze", {25'd0, w_dut}, {25'd0, 7'b1101011});
         step();
      end
      dmem_ready_M = 1;
      @(negedge clk); chk("freeze_redir", {25'd0, w_dut}, {25'd0, 7'b0010100});
      step(); idle();

      // asynchronous reset while in KILL
      pcsrc_E = 1; imem_ready = 0;
      step(); pcsrc_E = 0;
      step();
      rst_n = 0; imem_ready = 1;
      #1;
      chk("arst_outs", {25'd0, w_dut}, 32'd0);
      chk("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("arst_kill_cnt", {16'd0, kill_cnt}, 32'd0);
      step(); rst_n = 1;
      step();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         pcsrc_E      = ($urandom_range(0, 3) == 0);
         memread_E    = $urandom_range(0, 1) == 1;
         rd_E         = 5'($urandom_range(0, 3));
         rs1_D        = 5'($urandom_range(0, 3));
         rs2_D        = 5'($urandom_range(0, 3));
         imem_ready   = ($urandom_range(0, 2) != 0);
         dmem_req_M   = $urandom_range(0, 1) == 1;
         dmem_ready_M = $urandom_range(0, 1) == 1;
         cnt_clr      = ($urandom_range(0, 31) == 0);
         step();
      end
      idle();
      step();

      // saturation of the stall counter
      cnt_clr = 1;
      step(); cnt_clr = 0; imem_ready = 0;
      for (int i = 0; i < CAP + 6; i++) step();
      @(negedge clk); chk("stall_sat", {16'd0, stall_cnt}, {16'd0, 16'hFFFF});
      step(); cnt_clr = 1;
      step(); cnt_clr = 0; imem_ready = 1;
      @(negedge clk); chk("stall_clr", {16'd0, stall_cnt}, 32'd0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
